// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encodings,
// parity-type constants, default widths and a 2-of-3 vote helper.
package uart_pkg;

  localparam int DATA_WIDTH_DEF     = 8;
  localparam int PRESCALE_WIDTH_DEF = 6;

  // Receive FSM encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // PAR_TYP values
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // 2-of-3 vote used when three samples per bit are taken
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit timing for the UART receiver: edge counter within a bit, data-bit
// counter, and the registered bit sample.
// Build option UART_RX_MAJORITY_SAMPLE_EN: vote over three samples centred
// on the mid-bit point instead of one sample; timing is the same in both
// builds because the result is always published at edge_cnt == mid+1.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF,
  parameter int BIT_CNT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  input  logic                      in_data,
  input  logic                      rx_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      sampled_bit,
  output logic                      sample_stb,
  output logic                      bit_end,
  output logic [BIT_CNT_W-1:0]      bit_cnt
);

  logic [PRESCALE_WIDTH-1:0] edge_cnt_r;
  logic [PRESCALE_WIDTH-1:0] last_edge_s;
  logic [PRESCALE_WIDTH-1:0] mid_s;
  logic                      s_mid_r;
  logic                      vote_s;

  assign last_edge_s = prescale - PRESCALE_WIDTH'(1);
  assign mid_s       = prescale >> 1;
  assign bit_end     = run && (edge_cnt_r == last_edge_s);

  // Edge counter: 0..prescale-1 per bit, held at 0 while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_r <= '0;
    end else if (!run || bit_end) begin
      edge_cnt_r <= '0;
    end else begin
      edge_cnt_r <= edge_cnt_r + PRESCALE_WIDTH'(1);
    end
  end

  // Data-bit counter, advances at each data bit boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (!in_data) begin
      bit_cnt <= '0;
    end else if (bit_end) begin
      bit_cnt <= bit_cnt + BIT_CNT_W'(1);
    end else begin
      bit_cnt <= bit_cnt;
    end
  end

  // Mid-bit sample capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_mid_r <= 1'b0;
    end else if (run && (edge_cnt_r == mid_s)) begin
      s_mid_r <= rx_in;
    end else begin
      s_mid_r <= s_mid_r;
    end
  end

`ifdef UART_RX_MAJORITY_SAMPLE_EN
  logic s_early_r;

  // Early sample one cycle before mid-bit for the vote
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_early_r <= 1'b0;
    end else if (run && (edge_cnt_r == (mid_s - PRESCALE_WIDTH'(1)))) begin
      s_early_r <= rx_in;
    end else begin
      s_early_r <= s_early_r;
    end
  end

  // The late sample is the live line at edge_cnt == mid+1
  assign vote_s = majority3(s_early_r, s_mid_r, rx_in);
`else
  assign vote_s = s_mid_r;
`endif

  // Publish the bit value and a strobe at edge_cnt == mid+1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sampled_bit <= 1'b0;
      sample_stb  <= 1'b0;
    end else if (run && (edge_cnt_r == (mid_s + PRESCALE_WIDTH'(1)))) begin
      sampled_bit <= vote_s;
      sample_stb  <= 1'b1;
    end else begin
      sampled_bit <= sampled_bit;
      sample_stb  <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receive core: start detection, LSB-first deserialization, optional
// parity and stop-bit checks, one registered result pulse per frame.
// Build option UART_RX_MAJORITY_SAMPLE_EN selects 3-sample majority voting
// in uart_rx_sampler; default is a single mid-bit sample.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  logic [2:0]                state_r;
  logic [2:0]                state_nxt;
  logic                      par_en_r;
  logic                      par_typ_r;
  logic [PRESCALE_WIDTH-1:0] prescale_r;
  logic [DATA_WIDTH-1:0]     shift_r;
  logic                      glitch_r;
  logic                      par_flag_r;
  logic                      stp_flag_r;
  logic                      sampled_bit_s;
  logic                      sample_stb_s;
  logic                      bit_end_s;
  logic [BIT_CNT_W-1:0]      bit_cnt_s;
  logic                      run_s;
  logic                      in_data_s;

  // Expected parity bit for a payload: even -> XOR of data, odd -> inverted
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic typ);
    return (^d) ^ typ;
  endfunction

  assign run_s     = (state_r != ST_IDLE);
  assign in_data_s = (state_r == ST_DATA);

  uart_rx_sampler #(
    .DATA_WIDTH     (DATA_WIDTH),
    .PRESCALE_WIDTH (PRESCALE_WIDTH),
    .BIT_CNT_W      (BIT_CNT_W)
  ) u_sampler (
    .clk         (CLK),
    .rst_n       (RST),
    .run         (run_s),
    .in_data     (in_data_s),
    .rx_in       (RX_IN),
    .prescale    (prescale_r),
    .sampled_bit (sampled_bit_s),
    .sample_stb  (sample_stb_s),
    .bit_end     (bit_end_s),
    .bit_cnt     (bit_cnt_s)
  );

  // Next-state logic for the frame FSM
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!RX_IN) state_nxt = ST_START;
        else        state_nxt = ST_IDLE;
      end
      ST_START: begin
        if (bit_end_s) state_nxt = glitch_r ? ST_IDLE : ST_DATA;
        else           state_nxt = ST_START;
      end
      ST_DATA: begin
        if (bit_end_s && (bit_cnt_s == LAST_BIT)) state_nxt = par_en_r ? ST_PARITY : ST_STOP;
        else                                      state_nxt = ST_DATA;
      end
      ST_PARITY: begin
        if (bit_end_s) state_nxt = ST_STOP;
        else           state_nxt = ST_PARITY;
      end
      ST_STOP: begin
        if (bit_end_s) state_nxt = ST_IDLE;
        else           state_nxt = ST_STOP;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Frame config latch, deserializer, check flags and result pulses
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_en_r   <= 1'b0;
      par_typ_r  <= 1'b0;
      prescale_r <= '0;
      shift_r    <= '0;
      glitch_r   <= 1'b0;
      par_flag_r <= 1'b0;
      stp_flag_r <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!RX_IN) begin
            par_en_r   <= PAR_EN;
            par_typ_r  <= PAR_TYP;
            prescale_r <= Prescale;
            glitch_r   <= 1'b0;
            par_flag_r <= 1'b0;
            stp_flag_r <= 1'b0;
          end
        end
        ST_START: begin
          // A high mid-bit sample means the falling edge was noise
          if (sample_stb_s) glitch_r <= sampled_bit_s;
        end
        ST_DATA: begin
          if (sample_stb_s) shift_r <= {sampled_bit_s, shift_r[DATA_WIDTH-1:1]};
        end
        ST_PARITY: begin
          if (sample_stb_s) par_flag_r <= (sampled_bit_s != calc_parity(shift_r, par_typ_r));
        end
        ST_STOP: begin
          if (sample_stb_s) stp_flag_r <= ~sampled_bit_s;
          if (bit_end_s) begin
            if (!par_flag_r && !stp_flag_r) begin
              data_valid <= 1'b1;
              P_DATA     <= shift_r;
            end else begin
              par_err <= par_flag_r;
              stp_err <= stp_flag_r;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: the stimulus process pushes the expected
// pulse for each frame; a negedge monitor pops and compares every pulse.
module tb_uart_rx;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  typedef struct {
    logic [2:0] kind;   // {data_valid, par_err, stp_err}
    logic [7:0] data;
    int         cyc;    // negedge cycle the pulse must appear on, 0 = untimed
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_tests;
  int   n_fail;
  bit   done;

  uart_rx dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge CLK);
      cyc++;
    end
  end

  // Monitor: reset-value checks, pulse checks, final summary
  initial begin
    exp_t e;
    n_tests = 0;
    n_fail  = 0;
    forever begin
      @(negedge CLK);
      if (RST === 1'b0) begin
        n_tests++;
        if ({P_DATA, data_valid, par_err, stp_err} !== 11'd0) begin
          n_fail++;
          $display("FAIL reset_outputs: got P_DATA=%h dv=%b pe=%b se=%b, expected all 0",
                   P_DATA, data_valid, par_err, stp_err);
        end
      end else if (data_valid || par_err || stp_err) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: got dv/pe/se=%b at cycle %0d, expected none",
                   {data_valid, par_err, stp_err}, cyc);
        end else begin
          e = sb.pop_front();
          if ({data_valid, par_err, stp_err} !== e.kind) begin
            n_fail++;
            $display("FAIL pulse_kind: got dv/pe/se=%b, expected %b", {data_valid, par_err, stp_err}, e.kind);
          end
          n_tests++;
          if (P_DATA !== e.data) begin
            n_fail++;
            $display("FAIL p_data: got %h, expected %h", P_DATA, e.data);
          end
          if (e.cyc != 0) begin
            n_tests++;
            if (cyc != e.cyc) begin
              n_fail++;
              $display("FAIL pulse_time: got cycle %0d, expected cycle %0d", cyc, e.cyc);
            end
          end
        end
      end
      if (done) begin
        n_tests++;
        if (sb.size() != 0) begin
          n_fail++;
          $display("FAIL missing_pulse: %0d expected pulses never seen", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      RX_IN = 1'b1;
    end
  endtask

  // Drive one frame; gbit selects a frame bit (0 = start) to get a
  // one-cycle inversion at the receiver's mid-bit sample cycle.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic pbit, input logic stop, input logic [5:0] ps,
                            input int gbit, input bit timed,
                            input logic [2:0] exp_kind, input logic [7:0] exp_data);
    exp_t e;
    int   nbits;
    logic val;
    nbits = pe ? 11 : 10;
    for (int b = 0; b < nbits; b++) begin
      if (b == 0)                 val = 1'b0;
      else if (b <= 8)            val = d[b-1];
      else if (pe && (b == 9))    val = pbit;
      else                        val = stop;
      for (int j = 0; j < int'(ps); j++) begin
        @(negedge CLK);
        if ((b == 0) && (j == 0)) begin
          PAR_EN   = pe;
          PAR_TYP  = pt;
          Prescale = ps;
          e.kind   = exp_kind;
          e.data   = exp_data;
          e.cyc    = timed ? (cyc + 1 + nbits * int'(ps)) : 0;
          sb.push_back(e);
        end
        RX_IN = val ^ ((b == gbit) && (j == int'(ps) / 2 + 1));
      end
    end
  endtask

  // Stimulus
  initial begin
    done     = 1'b0;
    RST      = 1'b0;
    RX_IN    = 1'b1;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    Prescale = 6'd8;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    idle(4);

    // 1: no parity, Prescale 8
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 6'd8, -1, 1'b1, 3'b100, 8'hA5);
    idle(4);
    // 2: even parity, correct parity bit
    send_frame(8'hB4, 1'b1, 1'b0, 1'b0, 1'b1, 6'd16, -1, 1'b1, 3'b100, 8'hB4);
    idle(4);
    // 3: even parity, wrong parity bit
    send_frame(8'hB4, 1'b1, 1'b0, 1'b1, 1'b1, 6'd16, -1, 1'b1, 3'b010, 8'hB4);
    idle(4);
    // 4: bad stop bit, then good frame
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 6'd8, -1, 1'b1, 3'b001, 8'hB4);
    idle(4);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 6'd8, -1, 1'b1, 3'b100, 8'h3C);
    idle(4);
    // 4b: odd parity, correct (0x3C has four ones -> odd parity bit 1)
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 6'd8, -1, 1'b1, 3'b100, 8'h3C);
    idle(4);

    // 5: start glitch, then a good frame
    Prescale = 6'd16;
    @(negedge CLK); RX_IN = 1'b0;
    @(negedge CLK); RX_IN = 1'b0;
    idle(40);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 6'd16, -1, 1'b1, 3'b100, 8'h5A);
    idle(4);

    // 6: reset in the middle of a data bit, then back-to-back frames
    Prescale = 6'd32;
    PAR_EN   = 1'b0;
    for (int j = 0; j < 32; j++) begin @(negedge CLK); RX_IN = 1'b0; end
    for (int j = 0; j < 32; j++) begin @(negedge CLK); RX_IN = 1'b1; end
    for (int j = 0; j < 20; j++) begin @(negedge CLK); RX_IN = 1'b0; end
    @(negedge CLK);
    RST   = 1'b0;
    RX_IN = 1'b1;
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    idle(10);
    send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 6'd32, -1, 1'b1, 3'b100, 8'h01);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 6'd32, -1, 1'b0, 3'b100, 8'hFE);
    idle(10);

`ifdef UART_RX_MAJORITY_SAMPLE_EN
    // Single-cycle glitch at the mid-bit sample of data bit 2 and stop bit
    send_frame(8'h69, 1'b0, 1'b0, 1'b0, 1'b1, 6'd16, 3, 1'b1, 3'b100, 8'h69);
    idle(4);
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 6'd16, 9, 1'b1, 3'b100, 8'h96);
    idle(4);
`endif

    idle(4);
    done = 1'b1;
  end

endmodule
